// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Definitions shared by the LED pattern engine blocks (mode_tick_ctrl and the
// downstream pattern shifter).
//   mode_e          : pattern mode encoding carried on the 2-bit mode bus
//   DEB_CYCLES_DEF  : default switch debounce qualification length (cycles)
//   CNT_W_DEF       : default width of the step prescaler counter
//   PERIODn_DEF     : default step periods in clk cycles, speed 0 (slowest)
//                     through speed 3 (fastest)
// ----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'd0,
      MODE_FILL   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_ROTATE = 2'd3
   } mode_e;

   localparam logic [19:0] DEB_CYCLES_DEF = 20'd500000;
   localparam int          CNT_W_DEF      = 26;

   localparam logic [25:0] PERIOD0_DEF = 26'd50000000;
   localparam logic [25:0] PERIOD1_DEF = 26'd25000000;
   localparam logic [25:0] PERIOD2_DEF = 26'd12500000;
   localparam logic [25:0] PERIOD3_DEF = 26'd6250000;

endpackage

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// One switch bit: two-flop synchroniser followed by a debounce counter. The
// stable value only follows the synchronised input after it has differed
// for DEB_CYCLES consecutive cycles.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   raw    : asynchronous switch input
//   stable : debounced value (registered)
//   update : high in the cycle whose rising edge loads a new stable value
// ----------------------------------------------------------------------------
module sw_debounce
   import led_pkg::*;
#(
   parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic update
);

   logic        sync_p0;
   logic        sync_p1;
   logic [19:0] cnt;

   // Exposed combinationally so the parent can act on the same edge that
   // stable changes.
   assign update = (sync_p1 != stable) && (cnt == DEB_CYCLES - 20'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         stable  <= 1'b0;
         cnt     <= '0;
      end else begin
         // synchroniser stage boundary: raw -> p0 -> p1
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // debounce stage: any return to the stable value restarts the count
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (update) begin
            stable <= sync_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end

endmodule

// File: rtl/mode_tick_ctrl.sv
// ----------------------------------------------------------------------------
// mode_tick_ctrl
// Front-end control for the 8-LED pattern engine. Debounces the four slide
// switches into a pattern mode and a step-rate select, paces the pattern
// shifter with a one-cycle step enable and requests a seed reload after a
// mode change.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   sw[3:0]   : raw switches, [1:0] mode, [3:2] speed
//   mode      : debounced pattern mode (see led_pkg::mode_e)
//   speed     : debounced speed select
//   step_tick : one-cycle enable, once per selected period
//   mode_load : one-cycle pulse, the cycle after mode takes a new value
// ----------------------------------------------------------------------------
module mode_tick_ctrl
   import led_pkg::*;
#(
   parameter logic [19:0]      DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int               CNT_W      = CNT_W_DEF,
   parameter logic [CNT_W-1:0] PERIOD0    = CNT_W'(PERIOD0_DEF),
   parameter logic [CNT_W-1:0] PERIOD1    = CNT_W'(PERIOD1_DEF),
   parameter logic [CNT_W-1:0] PERIOD2    = CNT_W'(PERIOD2_DEF),
   parameter logic [CNT_W-1:0] PERIOD3    = CNT_W'(PERIOD3_DEF)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sw,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       step_tick,
   output logic       mode_load
);

   logic [3:0]       stable;
   logic [3:0]       update;
   logic             mode_upd;
   logic             any_upd;
   logic             mode_upd_p0;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic             cnt_last;

   for (genvar i = 0; i < 4; i++) begin : g_deb
      sw_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset  (reset),
         .raw    (sw[i]),
         .stable (stable[i]),
         .update (update[i])
      );
   end

   assign mode  = stable[1:0];
   assign speed = stable[3:2];

   // Both mode bits flipping on one edge still yields a single strobe.
   assign mode_upd = |update[1:0];
   assign any_upd  = |update;

   always_comb begin
      period = PERIOD0;
      case (speed)
         2'd0:    period = PERIOD0;
         2'd1:    period = PERIOD1;
         2'd2:    period = PERIOD2;
         default: period = PERIOD3;
      endcase
   end

   assign cnt_last = (cnt == period - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         step_tick   <= 1'b0;
         mode_upd_p0 <= 1'b0;
         mode_load   <= 1'b0;
      end else begin
         // mode_load stage boundary: delayed one cycle past the mode update
         mode_upd_p0 <= mode_upd;
         mode_load   <= mode_upd_p0;
         // prescaler stage: a mode or speed update restarts the period and
         // suppresses any tick pending on the old count. Since cnt is 0 after
         // a mode update and every period is >= 2, step_tick cannot coincide
         // with mode_load.
         if (any_upd) begin
            cnt       <= '0;
            step_tick <= 1'b0;
         end else if (cnt_last) begin
            cnt       <= '0;
            step_tick <= 1'b1;
         end else begin
            cnt       <= cnt + CNT_W'(1);
            step_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mode_tick_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mode_tick_ctrl
// Directed bench for mode_tick_ctrl with DEB_CYCLES=4 and periods 16/8/4/2.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same
// point so the next edge sees them.
// ----------------------------------------------------------------------------
module tb_mode_tick_ctrl;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] sw    = 4'b1111;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       step_tick;
   logic       mode_load;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mode_tick_ctrl #(
      .DEB_CYCLES (20'd4),
      .CNT_W      (5),
      .PERIOD0    (5'd16),
      .PERIOD1    (5'd8),
      .PERIOD2    (5'd4),
      .PERIOD3    (5'd2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .mode      (mode),
      .speed     (speed),
      .step_tick (step_tick),
      .mode_load (mode_load)
   );

   task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   // Advance one edge and check all outputs.
   task automatic chk(input string tag, input logic [1:0] m, input logic [1:0] s,
                      input logic t, input logic l);
      @(posedge clk);
      #1;
      cmp({tag, ".mode"},      {2'b00, mode},      {2'b00, m});
      cmp({tag, ".speed"},     {2'b00, speed},     {2'b00, s});
      cmp({tag, ".step_tick"}, {3'b000, step_tick}, {3'b000, t});
      cmp({tag, ".mode_load"}, {3'b000, mode_load}, {3'b000, l});
   endtask

   // n edges with constant mode/speed and no mode_load; a tick is expected on
   // edge index 'first' (1-based) and every 'per' edges after it.
   task automatic run(input string tag, input int n, input logic [1:0] m,
                      input logic [1:0] s, input int per, input int first);
      for (int i = 1; i <= n; i++)
         chk(tag, m, s, (i >= first) && (((i - first) % per) == 0), 1'b0);
   endtask

   initial begin
      // reset held three edges with all switches on
      chk("rst", 2'd0, 2'd0, 1'b0, 1'b0);
      chk("rst", 2'd0, 2'd0, 1'b0, 1'b0);
      chk("rst", 2'd0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      sw    = 4'b0000;
      run("idle", 40, 2'd0, 2'd0, 16, 16);

      // 3-cycle glitch on sw[0]; ticks keep their 16-cycle phase
      sw = 4'b0001;
      run("glitch", 3, 2'd0, 2'd0, 16, 8);
      sw = 4'b0000;
      run("glitch_after", 21, 2'd0, 2'd0, 16, 5);

      // clean mode change to 2
      sw = 4'b0010;
      run("mode_wait", 5, 2'd0, 2'd0, 16, 99);
      chk("mode_upd", 2'd2, 2'd0, 1'b0, 1'b0);
      chk("mode_load", 2'd2, 2'd0, 1'b0, 1'b1);
      run("mode_tick", 20, 2'd2, 2'd0, 16, 15);

      // back to mode 0
      sw = 4'b0000;
      run("mode0_wait", 5, 2'd2, 2'd0, 16, 99);
      chk("mode0_upd", 2'd0, 2'd0, 1'b0, 1'b0);
      chk("mode0_load", 2'd0, 2'd0, 1'b0, 1'b1);
      run("mode0_tick", 16, 2'd0, 2'd0, 16, 15);

      // speed change to 3, no stray tick at switchover
      sw = 4'b1100;
      run("spd_wait", 5, 2'd0, 2'd0, 16, 99);
      chk("spd_upd", 2'd0, 2'd3, 1'b0, 1'b0);
      run("spd3_tick", 10, 2'd0, 2'd3, 2, 2);

      // speed back to 0
      sw = 4'b0000;
      run("spd0_wait", 5, 2'd0, 2'd3, 2, 2);
      chk("spd0_upd", 2'd0, 2'd0, 1'b0, 1'b0);
      run("spd0_idle", 4, 2'd0, 2'd0, 16, 99);

      // simultaneous mode 3 / speed 1
      sw = 4'b0111;
      run("sim_wait", 5, 2'd0, 2'd0, 16, 99);
      chk("sim_upd", 2'd3, 2'd1, 1'b0, 1'b0);
      chk("sim_load", 2'd3, 2'd1, 1'b0, 1'b1);
      run("sim_tick", 16, 2'd3, 2'd1, 8, 7);

      // reset clears everything
      reset = 1'b1;
      sw    = 4'b0000;
      chk("rst2", 2'd0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;

      // reset in the middle of a debounce count
      sw = 4'b0001;
      run("mid_wait", 4, 2'd0, 2'd0, 16, 99);
      reset = 1'b1;
      chk("rst_mid", 2'd0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      run("mid_requal", 5, 2'd0, 2'd0, 16, 99);
      chk("mid_upd", 2'd1, 2'd0, 1'b0, 1'b0);
      chk("mid_load", 2'd1, 2'd0, 1'b0, 1'b1);
      run("mid_tick", 17, 2'd1, 2'd0, 16, 15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
